// File: rtl/ray_pkg.sv
// Shared types and constants for the ray/box intersection block.
package ray_pkg;

    localparam int unsigned DIR_W_DEFAULT = 32;
    localparam int unsigned POS_W_DEFAULT = 11;
    localparam int unsigned FRAC_DEFAULT  = 8;
    localparam int unsigned T_W_DEFAULT   = 32;
    localparam int unsigned IDX_W         = 32;
    localparam int unsigned DIV_CYCLES    = T_W_DEFAULT + 1;
    localparam int unsigned NUM_DIVIDES   = 6;

    localparam logic signed [T_W_DEFAULT-1:0] T_NEG_INF = {1'b1, {(T_W_DEFAULT-1){1'b0}}};
    localparam logic signed [T_W_DEFAULT-1:0] T_POS_INF = {1'b0, {(T_W_DEFAULT-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        COMBINE = 2'd2,
        OUTPUT  = 2'd3
    } isect_state_t;

endpackage

// File: rtl/ray_box_intersector_divider.sv
// Fixed-latency signed restoring divider: one setup cycle, then one quotient bit per cycle.
module seq_divider #(
    parameter int unsigned N_W = 20,
    parameter int unsigned D_W = 32,
    parameter int unsigned T_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic signed [N_W-1:0] num,
    input  logic signed [D_W-1:0] den,
    output logic                  busy,
    output logic                  done,
    output logic signed [T_W-1:0] quotient
);
    localparam int unsigned CNT_W = $clog2(T_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(T_W - 1);

    logic [T_W-1:0]   dvd;
    logic [D_W-1:0]   dmag;
    logic [D_W-1:0]   rem;
    logic [T_W-1:0]   q;
    logic             neg;
    logic [CNT_W-1:0] cnt;

    logic [N_W-1:0]   num_mag_c;
    logic [D_W-1:0]   den_mag_c;
    logic [D_W:0]     trial_c;
    logic             ge_c;
    logic [D_W-1:0]   rem_next_c;
    logic [T_W-1:0]   q_next_c;

    // Operand magnitudes and one restoring step.
    always_comb begin
        num_mag_c  = num[N_W-1] ? N_W'(-num) : N_W'(num);
        den_mag_c  = den[D_W-1] ? D_W'(-den) : D_W'(den);
        trial_c    = {rem, dvd[T_W-1]};
        ge_c       = (trial_c >= {1'b0, dmag});
        rem_next_c = ge_c ? D_W'(trial_c - {1'b0, dmag}) : D_W'(trial_c);
        q_next_c   = {q[T_W-2:0], ge_c};
    end

    // Setup on start, then iterate; sign is applied to the final quotient (truncation toward zero).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            quotient <= '0;
            dvd      <= '0;
            dmag     <= '0;
            rem      <= '0;
            q        <= '0;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                dvd  <= T_W'(num_mag_c);
                dmag <= den_mag_c;
                rem  <= '0;
                q    <= '0;
                neg  <= num[N_W-1] ^ den[D_W-1];
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                dvd <= dvd << 1;
                rem <= rem_next_c;
                q   <= q_next_c;
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST_ITER) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= neg ? T_W'(-q_next_c) : q_next_c;
                end
            end
        end
    end

endmodule

// File: rtl/ray_box_intersector.sv
// Slab-method ray vs. axis-aligned box test with one shared sequential divider.
module ray_box_intersector #(
    parameter int unsigned DIR_W = ray_pkg::DIR_W_DEFAULT,
    parameter int unsigned POS_W = ray_pkg::POS_W_DEFAULT,
    parameter int unsigned FRAC  = ray_pkg::FRAC_DEFAULT,
    parameter int unsigned T_W   = ray_pkg::T_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DIR_W-1:0] ray_dir_x,
    input  logic signed [DIR_W-1:0] ray_dir_y,
    input  logic signed [DIR_W-1:0] ray_dir_z,
    input  logic [31:0]             ray_index,
    input  logic signed [POS_W-1:0] origin_x,
    input  logic signed [POS_W-1:0] origin_y,
    input  logic signed [POS_W-1:0] origin_z,
    input  logic signed [POS_W-1:0] box_min_x,
    input  logic signed [POS_W-1:0] box_min_y,
    input  logic signed [POS_W-1:0] box_min_z,
    input  logic signed [POS_W-1:0] box_max_x,
    input  logic signed [POS_W-1:0] box_max_y,
    input  logic signed [POS_W-1:0] box_max_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_index,
    output logic                    out_hit,
    output logic [T_W-1:0]          out_t_near
);
    import ray_pkg::*;

    localparam int unsigned N_W = POS_W + 1 + FRAC;
    localparam logic signed [T_W-1:0] T_NEG = {1'b1, {(T_W-1){1'b0}}};
    localparam logic signed [T_W-1:0] T_POS = {1'b0, {(T_W-1){1'b1}}};
    localparam logic [2:0] LAST_DIV = 3'(NUM_DIVIDES - 1);

    isect_state_t state, state_next;

    logic signed [DIR_W-1:0] dir_r  [3];
    logic signed [POS_W-1:0] org_r  [3];
    logic signed [POS_W-1:0] bmin_r [3];
    logic signed [POS_W-1:0] bmax_r [3];
    logic [31:0]             idx_r;
    logic signed [T_W-1:0]   q_r    [NUM_DIVIDES];
    logic [2:0]              div_idx;
    logic                    kick;

    logic                    div_start_c;
    logic                    div_busy;
    logic                    div_done;
    logic signed [T_W-1:0]   div_quot;
    logic [2:0]              start_idx_c;
    logic signed [POS_W-1:0] sel_bound_c;
    logic signed [POS_W-1:0] sel_org_c;
    logic signed [DIR_W-1:0] sel_dir_c;
    logic signed [POS_W:0]   diff_c;
    logic signed [N_W-1:0]   num_c;

    logic                    axis_miss_c;
    logic signed [T_W-1:0]   t_near_c;
    logic signed [T_W-1:0]   t_far_c;
    logic                    hit_c;
    logic signed [T_W-1:0]   lo_c;
    logic signed [T_W-1:0]   hi_c;

    wire accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DIVIDE;
            DIVIDE:  if (div_done && div_idx == LAST_DIV) state_next = COMBINE;
            COMBINE: state_next = OUTPUT;
            OUTPUT:  if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake flags follow the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == OUTPUT);
        end
    end

    // Select operands for the divide about to start (x_min, x_max, y_min, ... z_max).
    always_comb begin
        div_start_c = kick || ((state == DIVIDE) && div_done && (div_idx != LAST_DIV));
        start_idx_c = kick ? 3'd0 : div_idx + 3'd1;
        case (start_idx_c[2:1])
            2'd0: begin
                sel_org_c   = org_r[0];
                sel_dir_c   = dir_r[0];
                sel_bound_c = start_idx_c[0] ? bmax_r[0] : bmin_r[0];
            end
            2'd1: begin
                sel_org_c   = org_r[1];
                sel_dir_c   = dir_r[1];
                sel_bound_c = start_idx_c[0] ? bmax_r[1] : bmin_r[1];
            end
            default: begin
                sel_org_c   = org_r[2];
                sel_dir_c   = dir_r[2];
                sel_bound_c = start_idx_c[0] ? bmax_r[2] : bmin_r[2];
            end
        endcase
        diff_c = {sel_bound_c[POS_W-1], sel_bound_c} - {sel_org_c[POS_W-1], sel_org_c};
        num_c  = {diff_c, {FRAC{1'b0}}};
    end

    seq_divider #(
        .N_W (N_W),
        .D_W (DIR_W),
        .T_W (T_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start_c),
        .num      (num_c),
        .den      (sel_dir_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Capture the ray at accept and collect quotients as each divide completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kick    <= 1'b0;
            div_idx <= '0;
        end else begin
            kick <= 1'b0;
            if (state == IDLE && accept) begin
                dir_r[0]  <= ray_dir_x;
                dir_r[1]  <= ray_dir_y;
                dir_r[2]  <= ray_dir_z;
                org_r[0]  <= origin_x;
                org_r[1]  <= origin_y;
                org_r[2]  <= origin_z;
                bmin_r[0] <= box_min_x;
                bmin_r[1] <= box_min_y;
                bmin_r[2] <= box_min_z;
                bmax_r[0] <= box_max_x;
                bmax_r[1] <= box_max_y;
                bmax_r[2] <= box_max_z;
                idx_r     <= ray_index;
                kick      <= 1'b1;
                div_idx   <= '0;
            end
            if (state == DIVIDE && div_done) begin
                q_r[div_idx] <= div_quot;
                if (div_idx != LAST_DIV) div_idx <= div_idx + 3'd1;
            end
        end
    end

    // Per-axis slab intervals folded into t_near/t_far; zero-direction axes are unbounded or a miss.
    always_comb begin
        axis_miss_c = 1'b0;
        t_near_c    = T_NEG;
        t_far_c     = T_POS;
        lo_c        = T_NEG;
        hi_c        = T_POS;
        for (int a = 0; a < 3; a++) begin
            lo_c = T_NEG;
            hi_c = T_POS;
            if (dir_r[a] != '0) begin
                lo_c = (q_r[2*a] < q_r[2*a+1]) ? q_r[2*a]   : q_r[2*a+1];
                hi_c = (q_r[2*a] < q_r[2*a+1]) ? q_r[2*a+1] : q_r[2*a];
            end else if (!(bmin_r[a] <= org_r[a] && org_r[a] <= bmax_r[a])) begin
                axis_miss_c = 1'b1;
            end
            if (lo_c > t_near_c) t_near_c = lo_c;
            if (hi_c < t_far_c)  t_far_c  = hi_c;
        end
        hit_c = !axis_miss_c && (t_near_c <= t_far_c) && (t_far_c >= 0);
    end

    // Result registers, loaded in COMBINE and held through OUTPUT; origin-inside clamps t_near to 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_index  <= '0;
            out_hit    <= 1'b0;
            out_t_near <= '0;
        end else if (state == COMBINE) begin
            out_index  <= idx_r;
            out_hit    <= hit_c;
            out_t_near <= (hit_c && !t_near_c[T_W-1]) ? t_near_c : '0;
        end
    end

endmodule

// File: tb/tb_ray_box_intersector.sv
// Directed and randomized checks of ray_box_intersector against an integer slab model.
module tb_ray_box_intersector;

    localparam int LATENCY = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_index;
    logic        out_hit;
    logic [31:0] out_t_near;
    logic [31:0] g_index = 32'd0;

    int g_dir [3];
    int g_org [3];
    int g_min [3];
    int g_max [3];

    int     errors = 0;
    int     checks = 0;
    bit     exp_hit;
    longint exp_t;
    int     exp_index;

    logic signed [31:0] dir_x, dir_y, dir_z;
    logic signed [10:0] org_x, org_y, org_z, mn_x, mn_y, mn_z, mx_x, mx_y, mx_z;

    assign dir_x = g_dir[0];
    assign dir_y = g_dir[1];
    assign dir_z = g_dir[2];
    assign org_x = 11'(g_org[0]);
    assign org_y = 11'(g_org[1]);
    assign org_z = 11'(g_org[2]);
    assign mn_x  = 11'(g_min[0]);
    assign mn_y  = 11'(g_min[1]);
    assign mn_z  = 11'(g_min[2]);
    assign mx_x  = 11'(g_max[0]);
    assign mx_y  = 11'(g_max[1]);
    assign mx_z  = 11'(g_max[2]);

    always #5 clk = ~clk;

    ray_box_intersector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ray_dir_x  (dir_x),
        .ray_dir_y  (dir_y),
        .ray_dir_z  (dir_z),
        .ray_index  (g_index),
        .origin_x   (org_x),
        .origin_y   (org_y),
        .origin_z   (org_z),
        .box_min_x  (mn_x),
        .box_min_y  (mn_y),
        .box_min_z  (mn_z),
        .box_max_x  (mx_x),
        .box_max_y  (mx_y),
        .box_max_z  (mx_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_hit    (out_hit),
        .out_t_near (out_t_near)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Slab test on whole numbers: t = (bound - origin) * 2^8 / dir, truncated toward zero.
    function automatic void model(output bit hit, output longint tn);
        longint t_near = -64'sd2147483648;
        longint t_far  = 64'sd2147483647;
        bit     miss   = 1'b0;
        for (int a = 0; a < 3; a++) begin
            if (g_dir[a] == 0) begin
                if (g_org[a] < g_min[a] || g_org[a] > g_max[a]) miss = 1'b1;
            end else begin
                longint ta = (longint'(g_min[a] - g_org[a]) * 256) / longint'(g_dir[a]);
                longint tb = (longint'(g_max[a] - g_org[a]) * 256) / longint'(g_dir[a]);
                longint lo = (ta < tb) ? ta : tb;
                longint hi = (ta < tb) ? tb : ta;
                if (lo > t_near) t_near = lo;
                if (hi < t_far)  t_far  = hi;
            end
        end
        hit = !miss && (t_near <= t_far) && (t_far >= 0);
        tn  = hit ? ((t_near < 0) ? 0 : t_near) : 0;
    endfunction

    task automatic set_ray(input int dx, input int dy, input int dz, input int ox, input int oy, input int oz,
                           input int lo, input int hi);
        g_dir[0] = dx; g_dir[1] = dy; g_dir[2] = dz;
        g_org[0] = ox; g_org[1] = oy; g_org[2] = oz;
        for (int a = 0; a < 3; a++) begin
            g_min[a] = lo;
            g_max[a] = hi;
        end
    endtask

    // Present the current ray and return #1 after the accepting edge.
    task automatic send_ray(input int idx);
        int n = 0;
        g_index   = 32'(idx);
        exp_index = idx;
        in_valid  = 1'b1;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    // Wait for out_valid, check latency and payload, optionally complete the handshake.
    task automatic wait_result(input string tag, input bit ack);
        int cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
        check({tag, "_hit"},     64'(out_hit), 64'(exp_hit));
        check({tag, "_t_near"},  64'(out_t_near), 64'(exp_t));
        check({tag, "_index"},   64'(out_index), 64'(32'(exp_index)));
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
            check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int     seen_valid;
        logic   hold_hit;
        logic [31:0] hold_t, hold_idx;

        set_ray(1, 1, 1, 0, 0, 0, 10, 20);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_in_ready",  64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_hit",   64'(out_hit), 64'd0);
        check("reset_out_index", 64'(out_index), 64'd0);
        check("reset_out_t",     64'(out_t_near), 64'd0);

        // Diagonal ray into the box.
        set_ray(1, 1, 1, 0, 0, 0, 10, 20);
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(0);
        wait_result("diag", 1'b1);

        // Axis-parallel ray: inside slabs on y/z, then outside on y.
        set_ray(1, 0, 0, 0, 15, 15, 10, 20);
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(1);
        wait_result("xonly_in", 1'b1);
        set_ray(1, 0, 0, 0, 25, 15, 10, 20);
        exp_hit = 1'b0; exp_t = 0;
        send_ray(2);
        wait_result("xonly_out", 1'b1);

        // Origin inside the box clamps t_near; non-unit direction truncates.
        set_ray(1, 1, 1, 15, 15, 15, 10, 20);
        exp_hit = 1'b1; exp_t = 0;
        send_ray(3);
        wait_result("inside", 1'b1);
        set_ray(3, 3, 3, 0, 0, 0, 10, 20);
        exp_hit = 1'b1; exp_t = 853;
        send_ray(5);
        wait_result("div3", 1'b1);

        // Box behind the ray, then negative x direction with a box on the negative side.
        set_ray(-1, -1, -1, 0, 0, 0, 10, 20);
        exp_hit = 1'b0; exp_t = 0;
        send_ray(6);
        wait_result("behind", 1'b1);
        set_ray(-1, 1, 1, 0, 0, 0, 10, 20);
        g_min[0] = -20; g_max[0] = -10;
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(7);
        wait_result("negx", 1'b1);

        // Backpressure: hold the result, then accept the next ray one cycle after the handshake.
        set_ray(1, 1, 1, 0, 0, 0, 10, 20);
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(0);
        wait_result("bp0", 1'b0);
        hold_hit = out_hit; hold_t = out_t_near; hold_idx = out_index;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready), 64'd0);
            check("bp_t_stable",   64'(out_t_near), 64'(hold_t));
            check("bp_idx_stable", 64'(out_index), 64'(hold_idx));
            check("bp_hit_stable", 64'(out_hit), 64'(hold_hit));
        end
        set_ray(3, 3, 3, 0, 0, 0, 10, 20);
        g_index = 32'd4; exp_index = 4; exp_hit = 1'b1; exp_t = 853;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_handshake_valid", 64'(out_valid), 64'd0);
        check("bp_handshake_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", 64'(in_ready), 64'd0);
        wait_result("bp4", 1'b1);
        set_ray(1, 0, 0, 0, 15, 15, 10, 20);
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(8);
        wait_result("bp8", 1'b1);

        // Reset during a divide aborts the ray.
        set_ray(1, 1, 1, 0, 0, 0, 10, 20);
        exp_hit = 1'b1; exp_t = 2560;
        send_ray(9);
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_in_ready",  64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        reset_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        check("midreset_no_stale", 64'(seen_valid), 64'd0);
        set_ray(3, 3, 3, 0, 0, 0, 10, 20);
        exp_hit = 1'b1; exp_t = 853;
        send_ray(10);
        wait_result("post_reset", 1'b1);

        // Random rays; inputs are scrambled after accept to confirm they were captured.
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a < 3; a++) begin
                int lo = int'($urandom_range(0, 80)) - 40;
                int hi = lo + int'($urandom_range(0, 60));
                g_min[a] = lo;
                g_max[a] = hi;
                g_org[a] = int'($urandom_range(0, 120)) - 60;
                g_dir[a] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 600)) - 300;
            end
            model(exp_hit, exp_t);
            send_ray(100 + r);
            for (int a = 0; a < 3; a++) begin
                g_dir[a] = int'($urandom_range(0, 600)) - 300;
                g_org[a] = int'($urandom_range(0, 120)) - 60;
                g_min[a] = -500;
                g_max[a] = 500;
            end
            wait_result("rand", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
